// File: rtl/watch_pkg.sv
// Shared definitions for the watch top level: block indices and the
// alarm arbitration state encoding.
package watch_pkg;

  localparam int unsigned NMODES = 7;
  localparam int unsigned IDX_W  = 3;

  localparam int unsigned MODE_DATE      = 0;
  localparam int unsigned MODE_CLOCK     = 1;
  localparam int unsigned MODE_ALARM     = 2;
  localparam int unsigned MODE_STOPWATCH = 3;
  localparam int unsigned MODE_TIMER     = 4;
  localparam int unsigned MODE_DDAY      = 5;
  localparam int unsigned MODE_LADDER    = 6;

  typedef enum logic [1:0] {
    ALM_IDLE = 2'd0,
    ALM_RING = 2'd1,
    ALM_ACK  = 2'd2
  } alm_state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronized button level. History resets
// to 1 so a button held through reset does not register as a press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic edge_c
);

  logic x_d;
  logic x_q;

  always_comb x_d = x;

  always_ff @(posedge clk) begin
    if (rst) x_q <= 1'b1;
    else     x_q <= x_d;
  end

  assign edge_c = x & ~x_q;

endmodule

// File: rtl/mode_sched.sv
// Central mode controller: owns the one-hot block enable, rotates it on
// button presses, arbitrates alarm requests and muxes the active display.
module mode_sched #(
  parameter int unsigned NMODES  = watch_pkg::NMODES,
  parameter int unsigned DISP_W  = 48,
  parameter int unsigned HOME    = watch_pkg::MODE_STOPWATCH,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up,
  input  logic                     down,
  input  logic                     esc,
  input  logic [NMODES-1:0]        norm,
  input  logic [NMODES-1:0]        alm_req,
  input  logic [NMODES*DISP_W-1:0] disp_in,
  output logic [NMODES-1:0]        mode,
  output logic [2:0]               mode_idx,
  output logic [DISP_W-1:0]        out,
  output logic                     alm,
  output logic [2:0]               alm_src
);

  import watch_pkg::*;

  localparam int unsigned       CNT_W    = 10;
  localparam logic [NMODES-1:0] HOME_OH  = NMODES'(1) << HOME;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  alm_state_e          state_q, state_d;
  logic [NMODES-1:0]   mode_q, mode_d;
  logic [NMODES-1:0]   prev_q, prev_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [DISP_W-1:0]   out_q, out_d;
  logic                alm_q, alm_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                up_e, dn_e, esc_e, any_e;
  logic                act_norm_c, req_hit_c;
  logic [IDX_W-1:0]    low_idx_c;
  logic [NMODES-1:0]   low_oh_c, src_oh_c;

  btn_edge u_up  (.clk(clk), .rst(rst), .x(up),   .edge_c(up_e));
  btn_edge u_dn  (.clk(clk), .rst(rst), .x(down), .edge_c(dn_e));
  btn_edge u_esc (.clk(clk), .rst(rst), .x(esc),  .edge_c(esc_e));

  // Lowest-index request wins arbitration; src_oh tracks the owning block.
  always_comb begin
    low_idx_c = '0;
    low_oh_c  = '0;
    src_oh_c  = '0;
    for (int i = NMODES - 1; i >= 0; i--) begin
      if (alm_req[i]) begin
        low_idx_c = IDX_W'(i);
        low_oh_c  = NMODES'(1) << i;
      end
    end
    for (int i = 0; i < NMODES; i++) begin
      if (src_q == IDX_W'(i)) src_oh_c[i] = 1'b1;
    end
    req_hit_c  = |(alm_req & src_oh_c);
    act_norm_c = |(mode_q & norm);
    any_e      = up_e | dn_e | esc_e;
  end

  // Alarm FSM, idle timeout and rotation, in that priority order.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    prev_d  = prev_q;
    src_d   = src_q;
    alm_d   = alm_q;
    cnt_d   = '0;
    idx_d   = '0;
    out_d   = '0;

    case (state_q)
      ALM_IDLE: begin
        if (|alm_req) begin
          state_d = ALM_RING;
          src_d   = low_idx_c;
          prev_d  = mode_q;
          mode_d  = low_oh_c;
          alm_d   = 1'b1;
        end else if (!any_e && act_norm_c && (mode_q != HOME_OH)) begin
          if (cnt_q == CNT_LAST) mode_d = HOME_OH;
          else                   cnt_d  = cnt_q + CNT_W'(1);
        end else if (act_norm_c && up_e && !dn_e) begin
          mode_d = {mode_q[NMODES-2:0], mode_q[NMODES-1]};
        end else if (act_norm_c && dn_e && !up_e) begin
          mode_d = {mode_q[0], mode_q[NMODES-1:1]};
        end
      end
      ALM_RING: begin
        // Acknowledge consumes the press; a dropped request also ends the ring.
        if (any_e || !req_hit_c) begin
          state_d = any_e ? ALM_ACK : ALM_IDLE;
          mode_d  = prev_q;
          alm_d   = 1'b0;
        end
      end
      ALM_ACK: begin
        if (!req_hit_c) state_d = ALM_IDLE;
      end
      default: state_d = ALM_IDLE;
    endcase

    for (int i = 0; i < NMODES; i++) begin
      if (mode_d[i]) idx_d = IDX_W'(i);
    end
    for (int i = 0; i < NMODES; i++) begin
      if (idx_q == IDX_W'(i)) out_d = disp_in[i*DISP_W +: DISP_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALM_IDLE;
      mode_q  <= HOME_OH;
      prev_q  <= HOME_OH;
      idx_q   <= IDX_W'(HOME);
      src_q   <= '0;
      out_q   <= '0;
      alm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      out_q   <= out_d;
      alm_q   <= alm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mode     = mode_q;
  assign mode_idx = idx_q;
  assign out      = out_q;
  assign alm      = alm_q;
  assign alm_src  = src_q;

endmodule

// File: tb/tb_mode_sched.sv
// Bench for mode_sched: directed vector table, a timeout sequence, then
// randomized traffic compared against an index-based reference model.
module tb_mode_sched;

  localparam int unsigned NM = 7;
  localparam int unsigned DW = 48;
  localparam int unsigned HM = 3;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst, up, down, esc;
  logic [NM-1:0]     norm, alm_req;
  logic [NM*DW-1:0]  disp_in;
  logic [NM-1:0]     mode;
  logic [2:0]        mode_idx;
  logic [DW-1:0]     out;
  logic              alm;
  logic [2:0]        alm_src;

  int checks = 0;
  int failures = 0;

  mode_sched #(.NMODES(NM), .DISP_W(DW), .HOME(HM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .esc(esc),
    .norm(norm), .alm_req(alm_req), .disp_in(disp_in),
    .mode(mode), .mode_idx(mode_idx), .out(out), .alm(alm), .alm_src(alm_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, up, dn, esc;
    logic [6:0] norm, req, exp_mode;
    logic       exp_alm;
    logic [2:0] exp_src;
  } vec_t;

  vec_t vecs [31];

  function automatic vec_t mk(input logic r, input logic u, input logic d, input logic e,
                              input logic [6:0] n, input logic [6:0] q, input logic [6:0] m,
                              input logic a, input logic [2:0] s);
    vec_t v;
    v.rst = r; v.up = u; v.dn = d; v.esc = e;
    v.norm = n; v.req = q; v.exp_mode = m; v.exp_alm = a; v.exp_src = s;
    return v;
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    return {16'hC0DE, 16'(i), 16'(i * 3 + 5)};
  endfunction

  function automatic int oh2i(input logic [6:0] m);
    int r = 0;
    for (int i = 0; i < 7; i++) if (m[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic u, input logic d, input logic e,
                       input logic [6:0] n, input logic [6:0] q);
    rst = r; up = u; down = d; esc = e; norm = n; alm_req = q;
    @(posedge clk);
    #1;
  endtask

  // Reference model: mode kept as an integer index, timeout as elapsed idle cycles.
  int          m_idx = HM, m_prev = HM, m_src = 0, m_st = 0, m_cnt = 0;
  bit          m_alm = 1'b0;
  logic [DW-1:0] m_out = '0;
  bit          pu = 1'b1, pd = 1'b1, pe = 1'b1;

  always @(posedge clk) begin
    bit eu, ed, ee, anyb;
    int lo;
    eu = up && !pu;
    ed = down && !pd;
    ee = esc && !pe;
    anyb = eu || ed || ee;
    if (rst) begin
      m_idx = HM; m_prev = HM; m_src = 0; m_st = 0; m_cnt = 0;
      m_alm = 1'b0; m_out = '0;
      pu = 1'b1; pd = 1'b1; pe = 1'b1;
    end else begin
      m_out = disp_in[m_idx*DW +: DW];
      if (m_st == 0) begin
        if (alm_req != 0) begin
          lo = 0;
          for (int i = 6; i >= 0; i--) if (alm_req[i]) lo = i;
          m_src = lo; m_prev = m_idx; m_idx = lo; m_alm = 1'b1; m_st = 1; m_cnt = 0;
        end else if (anyb || !norm[m_idx] || m_idx == HM) begin
          m_cnt = 0;
          if (norm[m_idx] && eu && !ed) m_idx = (m_idx + 1) % 7;
          else if (norm[m_idx] && ed && !eu) m_idx = (m_idx + 6) % 7;
        end else begin
          m_cnt++;
          if (m_cnt == TO) begin
            m_idx = HM;
            m_cnt = 0;
          end
        end
      end else if (m_st == 1) begin
        m_cnt = 0;
        if (anyb) begin
          m_st = 2; m_alm = 1'b0; m_idx = m_prev;
        end else if (!alm_req[m_src]) begin
          m_st = 0; m_alm = 1'b0; m_idx = m_prev;
        end
      end else begin
        m_cnt = 0;
        if (!alm_req[m_src]) m_st = 0;
      end
      pu = up; pd = down; pe = esc;
    end
  end

  initial begin
    int prev_i;
    int b;
    logic r_up, r_dn, r_esc, rr;
    logic [6:0] r_req, r_norm;

    rst = 1'b1; up = 1'b0; down = 1'b0; esc = 1'b0; norm = 7'h7F; alm_req = '0;
    for (int i = 0; i < NM; i++) disp_in[i*DW +: DW] = pat(i);

    //                rst up dn esc norm   req    mode         alm src
    vecs[0]  = mk(1, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 7'h7F, 7'h00, 7'b0010000, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0010000, 0, 0);
    vecs[4]  = mk(0, 0, 1, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 7'h77, 7'h00, 7'b0001000, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 7'h77, 7'h00, 7'b0001000, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 7'h7F, 7'h00, 7'b0000100, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0000100, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 7'h7F, 7'h00, 7'b0000010, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0000010, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 7'h7F, 7'h00, 7'b0000001, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0000001, 0, 0);
    vecs[14] = mk(0, 0, 1, 0, 7'h7F, 7'h00, 7'b1000000, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b1000000, 0, 0);
    vecs[16] = mk(0, 1, 1, 0, 7'h7F, 7'h00, 7'b1000000, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b1000000, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 7'h7F, 7'h14, 7'b0000100, 1, 2);
    vecs[21] = mk(0, 0, 0, 1, 7'h7F, 7'h14, 7'b0001000, 0, 2);
    vecs[22] = mk(0, 0, 0, 0, 7'h7F, 7'h14, 7'b0001000, 0, 2);
    vecs[23] = mk(0, 0, 0, 0, 7'h7F, 7'h10, 7'b0001000, 0, 2);
    vecs[24] = mk(0, 0, 0, 0, 7'h7F, 7'h10, 7'b0010000, 1, 4);
    vecs[25] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 4);
    vecs[26] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 4);
    vecs[27] = mk(0, 1, 0, 0, 7'h7F, 7'h01, 7'b0000001, 1, 0);
    vecs[28] = mk(1, 1, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[29] = mk(0, 1, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);
    vecs[30] = mk(0, 0, 0, 0, 7'h7F, 7'h00, 7'b0001000, 0, 0);

    prev_i = HM;
    for (int r = 0; r < 31; r++) begin
      drive(vecs[r].rst, vecs[r].up, vecs[r].dn, vecs[r].esc, vecs[r].norm, vecs[r].req);
      chk($sformatf("row%0d mode", r), 64'(mode), 64'(vecs[r].exp_mode));
      chk($sformatf("row%0d mode_idx", r), 64'(mode_idx), 64'(oh2i(vecs[r].exp_mode)));
      chk($sformatf("row%0d alm", r), 64'(alm), 64'(vecs[r].exp_alm));
      chk($sformatf("row%0d alm_src", r), 64'(alm_src), 64'(vecs[r].exp_src));
      chk($sformatf("row%0d out", r), 64'(out), vecs[r].rst ? 64'd0 : 64'(pat(prev_i)));
      prev_i = oh2i(vecs[r].exp_mode);
    end

    // Timeout: from mode 1, home is forced exactly TO idle cycles later.
    drive(0, 0, 1, 0, 7'h7F, 7'h00);
    drive(0, 0, 0, 0, 7'h7F, 7'h00);
    drive(0, 0, 1, 0, 7'h7F, 7'h00);
    chk("to_start mode", 64'(mode), 64'(7'b0000010));
    for (int n = 1; n <= 8; n++) begin
      drive(0, 0, 0, 0, 7'h7F, 7'h00);
      chk($sformatf("to_a n%0d mode", n), 64'(mode), (n == 8) ? 64'(7'b0001000) : 64'(7'b0000010));
    end

    // A button edge at cycle 5 restarts the count.
    drive(0, 0, 1, 0, 7'h7F, 7'h00);
    drive(0, 0, 0, 0, 7'h7F, 7'h00);
    drive(0, 0, 1, 0, 7'h7F, 7'h00);
    for (int n = 1; n <= 13; n++) begin
      drive(0, 0, 0, (n == 5), 7'h7F, 7'h00);
      chk($sformatf("to_b n%0d mode", n), 64'(mode), (n == 13) ? 64'(7'b0001000) : 64'(7'b0000010));
    end

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 7'h7F, 7'h00);
    r_up = 0; r_dn = 0; r_esc = 0; r_req = '0; r_norm = 7'h7F;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(23) == 0) r_up = ~r_up;
      if ($urandom_range(23) == 0) r_dn = ~r_dn;
      if ($urandom_range(23) == 0) r_esc = ~r_esc;
      if (r_req != 0 && $urandom_range(24) == 0) r_req = '0;
      if ($urandom_range(99) == 0) begin
        b = $urandom_range(6);
        r_req[b] = 1'b1;
      end
      if ($urandom_range(19) == 0) r_norm = ($urandom_range(1) == 1) ? 7'h7F : 7'($urandom);
      rr = ($urandom_range(499) == 0);
      for (int i = 0; i < NM; i++) disp_in[i*DW +: DW] = {16'($urandom), 32'($urandom)};
      drive(rr, r_up, r_dn, r_esc, r_norm, r_req);
      chk($sformatf("rnd%0d mode", c), 64'(mode), 64'(7'(1) << m_idx));
      chk($sformatf("rnd%0d mode_idx", c), 64'(mode_idx), 64'(m_idx));
      chk($sformatf("rnd%0d out", c), 64'(out), 64'(m_out));
      chk($sformatf("rnd%0d alm", c), 64'(alm), 64'(m_alm));
      chk($sformatf("rnd%0d alm_src", c), 64'(alm_src), 64'(m_src));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_sched.md
# mode_sched

Central mode controller for the watch top level. It owns the one-hot `mode` vector that enables exactly one function block (date, clock, alarm, stopwatch, timer, d_day, ladder). It rotates the mode on up/down presses only while the active block reports its normal state. It also arbitrates alarm requests from the function blocks and multiplexes the active block's 48-bit display word onto the display output.

## Interface
Parameters:
- `NMODES`, 7: number of function blocks and the width of `mode`.
- `DISP_W`, 48: display word width per block.
- `HOME`, 3: mode index selected at reset and on idle timeout (stopwatch).
- `TIMEOUT`, 1000: idle cycles before forced return to `HOME`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `up`, `down`, `esc`, in, 1 each: active-high button levels, already synchronized.
- `norm`, in, `NMODES`: bit i high when block i is in its normal (non-editing) state.
- `alm_req`, in, `NMODES`: level alarm requests; bit i is from block i.
- `disp_in`, in, `NMODES*DISP_W`: concatenated display words; block i occupies bits [i*DISP_W +: DISP_W].
- `mode`, out, `NMODES`: one-hot active-block enable.
- `mode_idx`, out, 3: binary index of `mode`.
- `out`, out, `DISP_W`: registered display word of the active block.
- `alm`, out, 1: alarm indicator.
- `alm_src`, out, 3: index of the block owning the current or last alarm.

## Operation
- **Edge detection.** Each button is edge-detected as `x & ~x_q`.
  - The `x_q` registers reset to 1, so a button held through reset produces no edge.
- **Rotation.** Allowed only in state IDLE and only when `(mode & norm) != 0`.
  - up edge: `mode <= {mode[NMODES-2:0], mode[NMODES-1]}`.
  - down edge: rotate the other way.
  - up and down edges in the same cycle: no change.
  - Wrap-around: 6 -> 0 on up, 0 -> 6 on down.
- **Alarm FSM** (IDLE, RING, ACK).
  - IDLE -> RING when any `alm_req` bit is high.
    - `alm_src` latches the lowest set index.
    - `prev_mode` saves `mode`.
    - `mode` is forced to one-hot(`alm_src`).
    - `alm` goes to 1.
  - RING -> ACK on any up/down/esc edge.
    - `alm` goes to 0.
    - `mode` is restored from `prev_mode`.
    - The button edge is consumed and causes no rotation.
  - RING -> IDLE if `alm_req[alm_src]` drops before acknowledge.
    - `alm` goes to 0.
    - `mode` is restored from `prev_mode`.
  - ACK -> IDLE when `alm_req[alm_src]` is 0. Requests from other sources are ignored while in ACK.
  - In RING, requests from other sources are ignored. No pre-emption.
- **Priority in one cycle:** reset > alarm entry > timeout > rotation.
- **Idle timeout** (IDLE only).
  - A 10-bit counter increments each cycle while there is no button edge, `mode != 1<<HOME`, and the active `norm` bit is 1.
  - It clears on any button edge, any mode change, or when the active `norm` bit is 0.
  - When it reaches `TIMEOUT-1`: `mode <= 1<<HOME` and the counter clears.
- **Display.** `out <= disp_in` slice selected by `mode_idx`. `mode_idx` is the encoded `mode`, registered alongside it.
- **Reset values:**
  - `mode` = 1<<`HOME`, `mode_idx` = `HOME`, `prev_mode` = 1<<`HOME`.
  - `out` = 0, `alm` = 0, `alm_src` = 0.
  - FSM = IDLE, timeout counter = 0, edge registers = 1.
- **Reset mid-alarm:** the saved mode is discarded and the block returns to the reset values.

## Timing
- **Button edge:** a press first sampled high at edge k updates `mode` and `mode_idx` at edge k.
- **Display:** `out` reflects the new block at edge k+1, giving 1-cycle display latency.
- **Alarm entry:** `alm_req` first sampled high at edge k sets `alm`, `alm_src` and `mode` at edge k.
- **Acknowledge:** an ack edge at k clears `alm` and restores `mode` at k.
- **Timeout:** fires exactly `TIMEOUT` idle cycles after the last clearing event.
- `mode` is one-hot in every cycle, including the reset cycle.

## Structure
- Package `watch_pkg` holds:
  - `NMODES`;
  - mode index constants `MODE_DATE`=0, `MODE_CLOCK`=1, `MODE_ALARM`=2, `MODE_STOPWATCH`=3, `MODE_TIMER`=4, `MODE_DDAY`=5, `MODE_LADDER`=6;
  - the alarm FSM state encoding.
- Sub-module `btn_edge`: per-button edge detector with reset-to-1 history, instantiated three times.
- The one-hot-to-index encoder, display mux, FSM and timeout counter stay in `mode_sched`.

## Test plan
1. **Reset then up edge.** Assert `rst` for 1 cycle, `norm`=7'h7F, pulse up. Required: `mode` goes 7'b0001000 -> 7'b0010000 and `out` = slice 4 one cycle later.
2. **Editing blocks rotation.** Set `norm[3]`=0 and pulse up. Required: `mode` stays 7'b0001000.
3. **Wrap and simultaneous press.** With `mode`=7'b0000001, down edge gives 7'b1000000. Up and down edges in the same cycle leave `mode` unchanged.
4. **Alarm arbitration.** With `mode`=7'b0001000, raise `alm_req[2]` and `alm_req[4]` together. Required: `alm`=1, `alm_src`=2, `mode`=7'b0000100. An esc edge then gives `alm`=0 and `mode`=7'b0001000; hold ACK until `alm_req[2]` drops.
5. **Idle timeout.** With `TIMEOUT`=8, `mode`=7'b0000010 and no buttons: `mode` returns to 7'b0001000 exactly 8 cycles later. A button edge at cycle 5 restarts the count.
6. **Reset during RING.** Required: `alm`=0, `mode`=7'b0001000, and a button held through reset produces no rotation.
